// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard and stall controller for a five-stage in-order pipeline.
//
// Combines three concerns:
//   * operand forwarding from M/W into E (combinational, valid in all states),
//   * load-use stalls and branch flushes for the front end,
//   * a data-memory wait FSM (RUN / MEM_WAIT / FAULT) that freezes the whole
//     pipeline while memory is busy and latches a fault on timeout.
//
// Optional build macro:
//   PIPE_CTRL_PERF_EN -- adds a saturating counter of cycles with StallF_o
//                        high.  Without it StallCnt_o is tied to zero and no
//                        counter flops exist.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT            = 255,
    parameter int PERF_WIDTH             = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
    input  logic [1:0]                        ResultSrcE_i,
    input  logic                              RegWriteM_i,
    input  logic                              RegWriteW_i,
    input  logic                              PCSrcE_i,
    input  logic                              MemReqM_i,
    input  logic                              MemReadyM_i,
    output logic                              StallF_o,
    output logic                              StallD_o,
    output logic                              EnE_o,
    output logic                              EnM_o,
    output logic                              EnW_o,
    output logic                              FlushD_o,
    output logic                              FlushE_o,
    output logic [1:0]                        ForwardAE_o,
    output logic [1:0]                        ForwardBE_o,
    output logic                              Fault_o,
    output logic [PERF_WIDTH-1:0]             StallCnt_o
);

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    localparam logic [REGISTER_ADDRESS_WIDTH-1:0] X0 = '0;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic in_fault;
    logic freeze;
    logic lw_stall;

    // Select the youngest in-flight producer of rs; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
        input logic                              reg_write_m,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
        input logic                              reg_write_w,
        input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m && (rd_m != X0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (reg_write_w && (rd_w != X0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign in_fault  = (state_q == FAULT);
    // Memory stall only matters while the FSM is still able to wait on it.
    assign mem_stall = MemReqM_i & ~MemReadyM_i & ~in_fault;
    assign freeze    = mem_stall | in_fault;
    assign lw_stall  = (ResultSrcE_i == 2'b01) && (RdE_i != X0) &&
                       ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    // Memory-wait FSM next state and wait-cycle counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned and infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);  // the first stall cycle counts as 1
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    // Memory answered (or the request was withdrawn).
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_VAL) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;  // left only through reset
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign Fault_o = in_fault;

    // Pipeline stall/enable/flush and forwarding selection.
    always_comb begin
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        EnE_o       = 1'b1;
        EnM_o       = 1'b1;
        EnW_o       = 1'b1;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        ForwardAE_o = fwd_sel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
        ForwardBE_o = fwd_sel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
        if (!rst_ni) begin
            // Hold the pipeline and keep bubbles flowing in while in reset.
            StallF_o    = 1'b1;
            StallD_o    = 1'b1;
            EnE_o       = 1'b0;
            EnM_o       = 1'b0;
            EnW_o       = 1'b0;
            FlushD_o    = 1'b1;
            FlushE_o    = 1'b1;
            ForwardAE_o = 2'b00;
            ForwardBE_o = 2'b00;
        end else if (freeze) begin
            // Full freeze: nothing moves and nothing is squashed.
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            EnE_o    = 1'b0;
            EnM_o    = 1'b0;
            EnW_o    = 1'b0;
        end else begin
            // A taken branch wins over a load-use stall: squash, don't hold.
            StallF_o = lw_stall & ~PCSrcE_i;
            StallD_o = lw_stall & ~PCSrcE_i;
            FlushD_o = PCSrcE_i;
            // A D->E flush is only meaningful when that register is enabled.
            FlushE_o = (lw_stall | PCSrcE_i) & EnE_o;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt_q;

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (StallF_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_WIDTH'(1);
        end
    end

    assign StallCnt_o = stall_cnt_q;
`else
    assign StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl (MEM_TIMEOUT = 4).
// The driver applies one directed vector per cycle and queues its
// hand-computed response; a monitor pops and compares on the falling edge.
// Honours PIPE_CTRL_PERF_EN for the expected stall count.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int RAW = 5;
    localparam int PW  = 16;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // {StallF, StallD, EnE, EnM, EnW, FlushD, FlushE}
    localparam logic [6:0] C_RUN = 7'b0011100;
    localparam logic [6:0] C_LW  = 7'b1111101;
    localparam logic [6:0] C_BR  = 7'b0011111;
    localparam logic [6:0] C_FRZ = 7'b1100000;
    localparam logic [6:0] C_RST = 7'b1100011;

    typedef struct packed {
        logic [RAW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]     rsrc;
        logic           rwm, rww, pcsrc, mreq, mrdy;
    } vin_t;

    typedef struct packed {
        int            id;
        logic [6:0]    ctrl;
        logic [1:0]    fa, fb;
        logic          flt;
        logic [PW-1:0] cnt;
    } exp_t;

    logic           clk, rst_n;
    logic [RAW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]     rsrc;
    logic           rwm, rww, pcsrc, mreq, mrdy;
    logic           stallf, stalld, ene, enm, enw, flushd, flushe, fault;
    logic [1:0]     fwda, fwdb;
    logic [PW-1:0]  stallcnt;

    exp_t          sb_q[$];
    int            checks = 0;
    int            fails  = 0;
    int            vec_id = 0;
    logic [PW-1:0] exp_cnt = '0;

    pipe_ctrl #(
        .REGISTER_ADDRESS_WIDTH(RAW),
        .MEM_TIMEOUT(4),
        .PERF_WIDTH(PW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .ResultSrcE_i(rsrc), .RegWriteM_i(rwm), .RegWriteW_i(rww),
        .PCSrcE_i(pcsrc), .MemReqM_i(mreq), .MemReadyM_i(mrdy),
        .StallF_o(stallf), .StallD_o(stalld),
        .EnE_o(ene), .EnM_o(enm), .EnW_o(enw),
        .FlushD_o(flushd), .FlushE_o(flushe),
        .ForwardAE_o(fwda), .ForwardBE_o(fwdb),
        .Fault_o(fault), .StallCnt_o(stallcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One cycle of stimulus plus its queued expectation.
    task automatic cyc(input vin_t v, input logic rst, input logic [6:0] c,
                       input logic [1:0] fa, input logic [1:0] fb, input logic flt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
        rde = v.rde; rdm = v.rdm; rdw = v.rdw; rsrc = v.rsrc;
        rwm = v.rwm; rww = v.rww; pcsrc = v.pcsrc; mreq = v.mreq; mrdy = v.mrdy;
        if (!rst) exp_cnt = '0;
        e.id   = vec_id;
        e.ctrl = c;
        e.fa   = fa;
        e.fb   = fb;
        e.flt  = flt;
        e.cnt  = PERF_EN ? exp_cnt : '0;
        sb_q.push_back(e);
        if (rst && c[6] && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        vec_id++;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("v%0d_ctrl", e.id),
                  32'({stallf, stalld, ene, enm, enw, flushd, flushe}), 32'(e.ctrl));
            check($sformatf("v%0d_fwdA", e.id), 32'(fwda), 32'(e.fa));
            check($sformatf("v%0d_fwdB", e.id), 32'(fwdb), 32'(e.fb));
            check($sformatf("v%0d_fault", e.id), 32'(fault), 32'(e.flt));
            check($sformatf("v%0d_stallcnt", e.id), 32'(stallcnt), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vin_t v;
        rst_n = 1'b0;
        {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
        rsrc = 2'b00;
        {rwm, rww, pcsrc, mreq, mrdy} = '0;

        // Reset: forwarding-matching inputs must still give 00.
        v = '0; v.rwm = 1; v.rdm = 3; v.rs1e = 3; v.pcsrc = 1;
        cyc(v, 1'b0, C_RST, 2'b00, 2'b00, 1'b0);
        v = '0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);

        // Forwarding.
        v = '0; v.rwm = 1; v.rdm = 3; v.rww = 1; v.rdw = 3; v.rs1e = 3;
        cyc(v, 1'b1, C_RUN, 2'b10, 2'b00, 1'b0);            // M beats W
        v = '0; v.rwm = 1; v.rdm = 0; v.rww = 1; v.rdw = 3; v.rs1e = 0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);            // x0 never forwarded
        v = '0; v.rwm = 1; v.rdm = 4; v.rs1e = 4; v.rww = 1; v.rdw = 7; v.rs2e = 7;
        cyc(v, 1'b1, C_RUN, 2'b10, 2'b01, 1'b0);
        v = '0; v.rwm = 0; v.rdm = 2; v.rs1e = 2; v.rww = 1; v.rdw = 9; v.rs2e = 9;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b01, 1'b0);            // M not writing
        v = '0; v.rww = 1; v.rdw = 0; v.rs1e = 0; v.rs2e = 0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);            // W x0
        v = '0; v.rwm = 1; v.rdm = 6; v.rww = 1; v.rdw = 6; v.rs2e = 6;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b10, 1'b0);

        // Load-use hazards.
        v = '0; v.rsrc = 2'b01; v.rde = 5; v.rs1d = 5;
        cyc(v, 1'b1, C_LW, 2'b00, 2'b00, 1'b0);
        v = '0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);            // one cycle only
        v = '0; v.rsrc = 2'b01; v.rde = 9; v.rs1d = 1; v.rs2d = 9;
        cyc(v, 1'b1, C_LW, 2'b00, 2'b00, 1'b0);
        v = '0; v.rsrc = 2'b01; v.rde = 0; v.rs1d = 0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);            // load to x0
        v = '0; v.rsrc = 2'b10; v.rde = 5; v.rs1d = 5;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);            // not a load

        // Branches.
        v = '0; v.rsrc = 2'b01; v.rde = 5; v.rs1d = 5; v.pcsrc = 1;
        cyc(v, 1'b1, C_BR, 2'b00, 2'b00, 1'b0);             // branch wins
        v = '0; v.pcsrc = 1;
        cyc(v, 1'b1, C_BR, 2'b00, 2'b00, 1'b0);

        // Memory wait: 3 stall cycles, then ready.
        v = '0; v.mreq = 1; v.mrdy = 0;
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        v.pcsrc = 1; v.rsrc = 2'b01; v.rde = 5; v.rs1d = 5;
        v.rwm = 1; v.rdm = 3; v.rs1e = 3;
        cyc(v, 1'b1, C_FRZ, 2'b10, 2'b00, 1'b0);            // freeze beats flush
        v = '0; v.mreq = 1; v.mrdy = 0;
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        v = '0; v.mreq = 1; v.mrdy = 1;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);
        v = '0; v.pcsrc = 1;
        cyc(v, 1'b1, C_BR, 2'b00, 2'b00, 1'b0);             // back in RUN

        // Timeout: RUN stall cycle + 4 MEM_WAIT cycles, then FAULT.
        v = '0; v.mreq = 1; v.mrdy = 0;
        for (int i = 0; i < 5; i++) cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b1);
        v = '0; v.mreq = 1; v.mrdy = 1; v.rww = 1; v.rdw = 8; v.rs1e = 8;
        cyc(v, 1'b1, C_FRZ, 2'b01, 2'b00, 1'b1);            // sticky, fwd live
        v = '0;
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b1);

        // Reset out of FAULT.
        cyc(v, 1'b0, C_RST, 2'b00, 2'b00, 1'b0);
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);
        v = '0; v.mreq = 1; v.mrdy = 0;
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        v = '0; v.mreq = 1; v.mrdy = 1;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);

        // Reset in the middle of MEM_WAIT.
        v = '0; v.mreq = 1; v.mrdy = 0;
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        cyc(v, 1'b1, C_FRZ, 2'b00, 2'b00, 1'b0);
        v = '0;
        cyc(v, 1'b0, C_RST, 2'b00, 2'b00, 1'b0);
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);
        v = '0; v.rsrc = 2'b01; v.rde = 4; v.rs2d = 4;
        cyc(v, 1'b1, C_LW, 2'b00, 2'b00, 1'b0);
        v = '0;
        cyc(v, 1'b1, C_RUN, 2'b00, 2'b00, 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
